// File: rtl/conv_window_accumulator.sv
// conv_window_accumulator: reduces 3x3 partial-product beats to window sums and
// accumulates them over a configured channel count into one pixel result.
module conv_window_accumulator #(
  parameter int ACC_W  = 24,
  parameter int MAX_CH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       cfg_channels,
  input  logic [143:0]     pp_bus,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] OUTPUT = 2'd3;
  localparam logic [4:0] MAX_C  = 5'(MAX_CH);

  logic [1:0]       state_q, state_d;
  logic [4:0]       beat_cnt_q, beat_cnt_d, ch_total_q, ch_total_d;
  logic [19:0]      tree_r_q, tree_r_d, tree_sum;
  logic             tree_vld_q, tree_vld_d;
  logic [ACC_W-1:0] acc_q, acc_d, out_sum_q, out_sum_d;
  logic             accept;

  assign in_ready  = state_q == ACCUM;
  assign out_valid = state_q == OUTPUT;
  assign busy      = state_q != IDLE;
  assign done      = out_valid && out_ready;
  assign out_sum   = out_sum_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < 9; i++) tree_sum = tree_sum + 20'(pp_bus[16*i +: 16]);
  end

  // Each accepted beat is added into acc one cycle later; DRAIN folds in the last one.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    ch_total_d = ch_total_q;
    tree_r_d   = tree_r_q;
    tree_vld_d = accept;
    acc_d      = acc_q;
    out_sum_d  = out_sum_q;
    if (state_q == IDLE && start) begin
      state_d    = ACCUM;
      ch_total_d = cfg_channels == 5'd0 ? 5'd1 : (cfg_channels > MAX_C ? MAX_C : cfg_channels);
      beat_cnt_d = '0;
      acc_d      = '0;
    end
    if (state_q == ACCUM && tree_vld_q) acc_d = acc_q + ACC_W'(tree_r_q);
    if (accept) begin
      tree_r_d   = tree_sum;
      beat_cnt_d = beat_cnt_q + 5'd1;
      if (beat_cnt_q + 5'd1 == ch_total_q) state_d = DRAIN;
    end
    if (state_q == DRAIN) begin
      out_sum_d = acc_q + ACC_W'(tree_r_q);
      state_d   = OUTPUT;
    end
    if (done) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      ch_total_q <= '0;
      tree_r_q   <= '0;
      tree_vld_q <= 1'b0;
      acc_q      <= '0;
      out_sum_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      ch_total_q <= ch_total_d;
      tree_r_q   <= tree_r_d;
      tree_vld_q <= tree_vld_d;
      acc_q      <= acc_d;
      out_sum_q  <= out_sum_d;
    end
  end
endmodule

// File: tb/tb_conv_window_accumulator.sv
// tb_conv_window_accumulator: random and directed pixels against a queue-based
// reference; a free-running monitor compares each output handshake.
module tb_conv_window_accumulator;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   cfg_channels = '0;
  logic [143:0] pp_bus = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [23:0]  out_sum;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         busy;
  logic         done;

  int passed = 0;
  int total = 0;
  longint exp_q[$];
  logic prev_hold = 1'b0;
  logic [23:0] prev_sum = '0;

  conv_window_accumulator #(.ACC_W(24), .MAX_CH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_channels(cfg_channels),
    .pp_bus(pp_bus), .in_valid(in_valid), .in_ready(in_ready), .out_sum(out_sum),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
  endtask

  always @(negedge clk) begin
    if (!rst_n) prev_hold <= 1'b0;
    else begin
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", out_sum, prev_sum);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
        else chk("out_sum", out_sum, exp_q.pop_front());
        chk("done_on_handshake", done, 1);
      end else if (done) chk("spurious_done", done, 0);
      prev_hold <= out_valid && !out_ready;
      prev_sum  <= out_sum;
    end
  end

  function automatic logic [143:0] make_beat(input int mode);
    logic [143:0] b;
    logic [15:0] fx[9] = '{16'h1234, 16'h5678, 16'h9abc, 16'hdef0, 16'h1234,
                           16'h5678, 16'h9abc, 16'hdef0, 16'h1111};
    for (int i = 0; i < 9; i++)
      b[16*i +: 16] = mode == 1 ? 16'hffff : mode == 2 ? 16'h0001 :
                      mode == 3 ? fx[i] : 16'($urandom);
    return b;
  endfunction

  function automatic longint beat_value(input logic [143:0] b);
    longint s = 0;
    for (int i = 0; i < 9; i++) s += longint'(b[16*i +: 16]);
    return s;
  endfunction

  // want < 0 means use the model sum; otherwise the known answer is pushed.
  task automatic pixel(input int cfg, input int mode, input int bubbles, input int stall,
                       input longint want);
    int eff, sent, guard;
    longint sum;
    eff = cfg == 0 ? 1 : (cfg > 16 ? 16 : cfg);
    sent = 0; guard = 0; sum = 0;
    out_ready = stall == 0;
    start = 1'b1; cfg_channels = 5'(cfg);
    @(posedge clk) #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (sent < eff && guard < 200) begin
      in_valid = bubbles ? sent[0] ^ guard[0] ^ 1'b1 : 1'b1;
      pp_bus = make_beat(mode);
      if (in_valid && in_ready) begin sum += beat_value(pp_bus); sent++; end
      guard++;
      @(posedge clk) #1;
    end
    in_valid = 1'b0;
    if (guard >= 200) chk("beat_timeout", guard, 0);
    exp_q.push_back(want < 0 ? sum : want);
    chk("in_ready_after_last", in_ready, 0);
    chk("valid_in_drain", out_valid, 0);
    @(posedge clk) #1;
    chk("latency_valid", out_valid, 1);
    for (int c = 0; c < stall; c++) begin
      start = 1'b1; in_valid = 1'b1; pp_bus = make_beat(0);
      #1;
      chk("stall_in_ready", in_ready, 0);
      @(posedge clk) #1;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("done_pulse", done, 1);
    @(posedge clk) #1;
    chk("idle_after_done", busy, 0);
    chk("done_cleared", done, 0);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk) #1;
    pixel(1, 3, 0, 0, 64'h03D5C1);
    pixel(3, 3, 1, 0, 64'h0B8143);
    pixel(16, 1, 0, 0, 64'h8FFF70);
    pixel(0, 2, 0, 0, 9);
    pixel(20, 0, 1, 0, -1);
    pixel(2, 0, 0, 5, -1);
    // abort a 4-channel pixel after 2 accepted beats
    start = 1'b1; cfg_channels = 5'd4;
    @(posedge clk) #1;
    start = 1'b0; in_valid = 1'b1; pp_bus = make_beat(1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_sum", out_sum, 0);
    @(posedge clk) #1 rst_n = 1'b1;
    @(posedge clk) #1;
    pixel(1, 2, 0, 0, 9);
    for (int k = 0; k < 12; k++)
      pixel(int'($urandom_range(0, 18)), 0, int'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), -1);
    repeat (4) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
